// File: rtl/cpu_pkg.sv
// Shared Mini SRC control definitions: opcodes, ALU codes, IR field positions,
// sequencer states and the decoded instruction-class / control-strobe bundles.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU_INC makes the ALU compute B+1 for the PC increment during fetch
  localparam logic [4:0] ALU_INC = 5'b11111;
  localparam logic [4:0] ALU_ADD = OP_ADD;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic ld;
    logic ldi;
    logic st;
    logic muldiv;
    logic unary;
    logic mfhi;
    logic mflo;
    logic jr;
    logic nop;
    logic halt;
    logic illegal;
  } instr_class_t;

  typedef struct packed {
    logic       pc_out;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       y_in;
    logic       z_in;
    logic       zlow_out;
    logic       zhigh_out;
    logic       hi_in;
    logic       hi_out;
    logic       lo_in;
    logic       lo_out;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       read;
    logic       write;
    logic [4:0] alu;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/memory status in, every
// datapath strobe and sequencer status flag out.
interface control_unit_if;
  logic [31:0] IR_Data;
  logic        mem_ready;
  logic        PC_out, PC_in, IR_in, MAR_in, MDR_in, MDR_out;
  logic        Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, HI_out, LO_in, LO_out, C_out;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Read, Write;
  logic [4:0]  alu_instruction;
  logic        run, illegal_op, mem_timeout;

  modport master (
    input  IR_Data, mem_ready,
    output PC_out, PC_in, IR_in, MAR_in, MDR_in, MDR_out,
    output Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, HI_out, LO_in, LO_out, C_out,
    output Gra, Grb, Grc, Rin, Rout, BAout, Read, Write,
    output alu_instruction, run, illegal_op, mem_timeout
  );

  modport slave (
    output IR_Data, mem_ready,
    input  PC_out, PC_in, IR_in, MAR_in, MDR_in, MDR_out,
    input  Y_in, Z_in, Zlow_out, Zhigh_out, HI_in, HI_out, LO_in, LO_out, C_out,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Read, Write,
    input  alu_instruction, run, illegal_op, mem_timeout
  );
endinterface

// File: rtl/cu_decode.sv
// Opcode classifier: maps the 5-bit opcode to a one-hot instruction class.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   i_opcode,
  output instr_class_t o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:     o_class.rtype  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:          o_class.imm    = 1'b1;
      OP_LD:                             o_class.ld     = 1'b1;
      OP_LDI:                            o_class.ldi    = 1'b1;
      OP_ST:                             o_class.st     = 1'b1;
      OP_MUL, OP_DIV:                    o_class.muldiv = 1'b1;
      OP_NEG, OP_NOT:                    o_class.unary  = 1'b1;
      OP_MFHI:                           o_class.mfhi   = 1'b1;
      OP_MFLO:                           o_class.mflo   = 1'b1;
      OP_JR:                             o_class.jr     = 1'b1;
      OP_NOP:                            o_class.nop    = 1'b1;
      OP_HALT:                           o_class.halt   = 1'b1;
      // branch, jal, in, out and 11100-11111 are not executed by this sequencer
      default:                           o_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC sequencer: steps T0-T7 per instruction, decodes strobes from
// (state, opcode), stalls memory states on mem_ready with an optional timeout.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 0
) (
  input logic            clk,
  input logic            clr,
  control_unit_if.master bus
);

  state_t       r_state;
  logic [31:0]  r_wait;
  logic         r_timeout;

  logic [4:0]   w_opcode;
  instr_class_t w_class;
  state_t       w_next;
  logic         w_mem_state;
  logic         w_illegal;
  ctrl_t        w_ctrl;

  assign w_opcode = bus.IR_Data[IR_OP_MSB:IR_OP_LSB];

  cu_decode u_decode (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

  assign w_mem_state = (r_state == ST_T1) ||
                       ((r_state == ST_T6) && w_class.ld) ||
                       ((r_state == ST_T7) && w_class.st);

  always_comb begin
    w_next = ST_T0;
    case (r_state)
      ST_T0: w_next = ST_T1;
      ST_T1: w_next = ST_T2;
      ST_T2: w_next = ST_T3;
      ST_T3: begin
        if (w_class.halt)
          w_next = ST_HALT;
        else if (w_class.rtype || w_class.imm || w_class.ldi || w_class.ld ||
                 w_class.st || w_class.muldiv || w_class.unary)
          w_next = ST_T4;
      end
      ST_T4:   w_next = w_class.unary ? ST_T0 : ST_T5;
      ST_T5:   w_next = (w_class.ld || w_class.st || w_class.muldiv) ? ST_T6 : ST_T0;
      ST_T6:   w_next = (w_class.ld || w_class.st) ? ST_T7 : ST_T0;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_T0;
    endcase
  end

  // A memory state holds until mem_ready; r_wait counts the unready cycles seen so far
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_T0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_mem_state && !bus.mem_ready) begin
        if ((WAIT_MAX != 0) && (r_wait == WAIT_MAX - 32'd1)) begin
          r_state   <= ST_HALT;
          r_wait    <= '0;
          r_timeout <= 1'b1;
        end else if (WAIT_MAX != 0) begin
          r_wait <= r_wait + 32'd1;
        end
      end else begin
        r_state <= w_next;
        r_wait  <= '0;
      end
    end
  end

  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (r_state)
      ST_T0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1; w_ctrl.z_in = 1'b1;
        w_ctrl.alu    = ALU_INC;
      end
      ST_T1: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = 1'b1;
        w_ctrl.read     = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      ST_T2: begin
        w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
      end
      ST_T3: begin
        if (w_class.rtype || w_class.imm) begin
          w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_class.ldi || w_class.ld || w_class.st) begin
          w_ctrl.grb = 1'b1; w_ctrl.baout = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_class.muldiv) begin
          w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_class.unary) begin
          w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
          w_ctrl.alu = w_opcode;
        end else if (w_class.mfhi) begin
          w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
        end else if (w_class.mflo) begin
          w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
        end else if (w_class.jr) begin
          w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_in = 1'b1;
        end else if (w_class.illegal) begin
          w_illegal = 1'b1;
        end
      end
      ST_T4: begin
        if (w_class.rtype) begin
          w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
          w_ctrl.alu = w_opcode;
        end else if (w_class.imm) begin
          w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu = w_opcode;
        end else if (w_class.ldi || w_class.ld || w_class.st) begin
          w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1; w_ctrl.alu = ALU_ADD;
        end else if (w_class.muldiv) begin
          w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
          w_ctrl.alu = w_opcode;
        end else if (w_class.unary) begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
        end
      end
      ST_T5: begin
        if (w_class.rtype || w_class.imm || w_class.ldi) begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
        end else if (w_class.ld || w_class.st) begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
        end else if (w_class.muldiv) begin
          w_ctrl.zlow_out = 1'b1; w_ctrl.lo_in = 1'b1;
        end
      end
      ST_T6: begin
        if (w_class.ld) begin
          w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
        end else if (w_class.st) begin
          w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdr_in = 1'b1;
        end else if (w_class.muldiv) begin
          w_ctrl.zhigh_out = 1'b1; w_ctrl.hi_in = 1'b1;
        end
      end
      ST_T7: begin
        if (w_class.ld) begin
          w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
        end else if (w_class.st) begin
          w_ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
    if (clr) begin
      w_ctrl    = '0;
      w_illegal = 1'b0;
    end
  end

  assign bus.PC_out          = w_ctrl.pc_out;
  assign bus.PC_in           = w_ctrl.pc_in;
  assign bus.IR_in           = w_ctrl.ir_in;
  assign bus.MAR_in          = w_ctrl.mar_in;
  assign bus.MDR_in          = w_ctrl.mdr_in;
  assign bus.MDR_out         = w_ctrl.mdr_out;
  assign bus.Y_in            = w_ctrl.y_in;
  assign bus.Z_in            = w_ctrl.z_in;
  assign bus.Zlow_out        = w_ctrl.zlow_out;
  assign bus.Zhigh_out       = w_ctrl.zhigh_out;
  assign bus.HI_in           = w_ctrl.hi_in;
  assign bus.HI_out          = w_ctrl.hi_out;
  assign bus.LO_in           = w_ctrl.lo_in;
  assign bus.LO_out          = w_ctrl.lo_out;
  assign bus.C_out           = w_ctrl.c_out;
  assign bus.Gra             = w_ctrl.gra;
  assign bus.Grb             = w_ctrl.grb;
  assign bus.Grc             = w_ctrl.grc;
  assign bus.Rin             = w_ctrl.rin;
  assign bus.Rout            = w_ctrl.rout;
  assign bus.BAout           = w_ctrl.baout;
  assign bus.Read            = w_ctrl.read;
  assign bus.Write           = w_ctrl.write;
  assign bus.alu_instruction = w_ctrl.alu;
  assign bus.run             = (r_state != ST_HALT);
  assign bus.illegal_op      = w_illegal;
  assign bus.mem_timeout     = r_timeout;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one expected strobe vector per cycle,
// covering fetch, each instruction class, memory stalls, clr and timeout.
module tb_control_unit;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  control_unit_if bus ();

  control_unit #(.WAIT_MAX(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [22:0] PC_OUT  = 23'd1 << 22;
  localparam logic [22:0] PC_IN   = 23'd1 << 21;
  localparam logic [22:0] IR_IN   = 23'd1 << 20;
  localparam logic [22:0] MAR_IN  = 23'd1 << 19;
  localparam logic [22:0] MDR_IN  = 23'd1 << 18;
  localparam logic [22:0] MDR_OUT = 23'd1 << 17;
  localparam logic [22:0] Y_IN    = 23'd1 << 16;
  localparam logic [22:0] Z_IN    = 23'd1 << 15;
  localparam logic [22:0] ZLOW    = 23'd1 << 14;
  localparam logic [22:0] ZHIGH   = 23'd1 << 13;
  localparam logic [22:0] HI_IN   = 23'd1 << 12;
  localparam logic [22:0] HI_OUT  = 23'd1 << 11;
  localparam logic [22:0] LO_IN   = 23'd1 << 10;
  localparam logic [22:0] LO_OUT  = 23'd1 << 9;
  localparam logic [22:0] C_OUT   = 23'd1 << 8;
  localparam logic [22:0] GRA     = 23'd1 << 7;
  localparam logic [22:0] GRB     = 23'd1 << 6;
  localparam logic [22:0] GRC     = 23'd1 << 5;
  localparam logic [22:0] RIN     = 23'd1 << 4;
  localparam logic [22:0] ROUT    = 23'd1 << 3;
  localparam logic [22:0] BAOUT   = 23'd1 << 2;
  localparam logic [22:0] READ    = 23'd1 << 1;
  localparam logic [22:0] WRITE   = 23'd1;
  localparam logic [22:0] NONE    = 23'd0;

  // flags = {run, illegal_op, mem_timeout}
  localparam logic [2:0] F_RUN  = 3'b100;
  localparam logic [2:0] F_ILL  = 3'b110;
  localparam logic [2:0] F_HALT = 3'b000;
  localparam logic [2:0] F_TO   = 3'b001;

  logic [30:0] w_obs;
  assign w_obs = {bus.PC_out, bus.PC_in, bus.IR_in, bus.MAR_in, bus.MDR_in, bus.MDR_out,
                  bus.Y_in, bus.Z_in, bus.Zlow_out, bus.Zhigh_out, bus.HI_in, bus.HI_out,
                  bus.LO_in, bus.LO_out, bus.C_out, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                  bus.Rout, bus.BAout, bus.Read, bus.Write, bus.alu_instruction,
                  bus.run, bus.illegal_op, bus.mem_timeout};

  function automatic logic [30:0] ex(input logic [22:0] s, input logic [4:0] alu,
                                     input logic [2:0] flags);
    return {s, alu, flags};
  endfunction

  // Checks the current cycle's outputs, then advances to just after the next edge
  task automatic cyc(input string tag, input logic [30:0] expv);
    #1;
    checks++;
    assert (w_obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, w_obs, expv);
    end
    $display("step %-14s obs=%h exp=%h", tag, w_obs, expv);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_t0"}, ex(PC_OUT | MAR_IN | Z_IN, 5'b11111, F_RUN));
    cyc({tag, "_t1"}, ex(ZLOW | PC_IN | READ | MDR_IN, 5'd0, F_RUN));
    cyc({tag, "_t2"}, ex(MDR_OUT | IR_IN, 5'd0, F_RUN));
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    clr           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.IR_Data   = 32'h19890000;
    @(posedge clk);
    #1;
    cyc("reset", ex(NONE, 5'd0, F_RUN));
    clr = 1'b0;

    // add r3,r1,r2
    fetch("add");
    cyc("add_t3", ex(GRB | ROUT | Y_IN, 5'd0, F_RUN));
    cyc("add_t4", ex(GRC | ROUT | Z_IN, 5'b00011, F_RUN));
    cyc("add_t5", ex(ZLOW | GRA | RIN, 5'd0, F_RUN));

    // ld r1,0x55(r2) with three unready cycles in T6
    bus.IR_Data = 32'h00900055;
    fetch("ld");
    cyc("ld_t3", ex(GRB | BAOUT | Y_IN, 5'd0, F_RUN));
    cyc("ld_t4", ex(C_OUT | Z_IN, 5'b00011, F_RUN));
    cyc("ld_t5", ex(ZLOW | MAR_IN, 5'd0, F_RUN));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_t6_wait", ex(READ | MDR_IN, 5'd0, F_RUN));
    bus.mem_ready = 1'b1;
    cyc("ld_t6_ready", ex(READ | MDR_IN, 5'd0, F_RUN));
    cyc("ld_t7", ex(MDR_OUT | GRA | RIN, 5'd0, F_RUN));

    // st 0x20(r3),r4
    bus.IR_Data = 32'h12180020;
    fetch("st");
    cyc("st_t3", ex(GRB | BAOUT | Y_IN, 5'd0, F_RUN));
    cyc("st_t4", ex(C_OUT | Z_IN, 5'b00011, F_RUN));
    cyc("st_t5", ex(ZLOW | MAR_IN, 5'd0, F_RUN));
    cyc("st_t6", ex(GRA | ROUT | MDR_IN, 5'd0, F_RUN));
    cyc("st_t7", ex(WRITE, 5'd0, F_RUN));

    // mul r4,r5
    bus.IR_Data = 32'h82280000;
    fetch("mul");
    cyc("mul_t3", ex(GRA | ROUT | Y_IN, 5'd0, F_RUN));
    cyc("mul_t4", ex(GRB | ROUT | Z_IN, 5'b10000, F_RUN));
    cyc("mul_t5", ex(ZLOW | LO_IN, 5'd0, F_RUN));
    cyc("mul_t6", ex(ZHIGH | HI_IN, 5'd0, F_RUN));

    // neg r1,r2
    bus.IR_Data = 32'h88900000;
    fetch("neg");
    cyc("neg_t3", ex(GRB | ROUT | Z_IN, 5'b10001, F_RUN));
    cyc("neg_t4", ex(ZLOW | GRA | RIN, 5'd0, F_RUN));

    // mfhi r6
    bus.IR_Data = 32'hC3000000;
    fetch("mfhi");
    cyc("mfhi_t3", ex(HI_OUT | GRA | RIN, 5'd0, F_RUN));

    // branch opcode is unsupported
    bus.IR_Data = 32'h98000000;
    fetch("ill");
    cyc("ill_t3", ex(NONE, 5'd0, F_ILL));

    // halt, hold, then recover with clr
    bus.IR_Data = 32'hD8000000;
    fetch("halt");
    cyc("halt_t3", ex(NONE, 5'd0, F_RUN));
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      cyc("halt_hold", ex(NONE, 5'd0, F_HALT));
    end
    clr           = 1'b1;
    bus.mem_ready = 1'b1;
    cyc("halt_clr", ex(NONE, 5'd0, F_HALT));
    clr         = 1'b0;
    bus.IR_Data = 32'h19890000;

    // clr during a T1 wait
    cyc("clr_t0", ex(PC_OUT | MAR_IN | Z_IN, 5'b11111, F_RUN));
    bus.mem_ready = 1'b0;
    cyc("midwait_t1a", ex(ZLOW | PC_IN | READ | MDR_IN, 5'd0, F_RUN));
    cyc("midwait_t1b", ex(ZLOW | PC_IN | READ | MDR_IN, 5'd0, F_RUN));
    clr           = 1'b1;
    bus.mem_ready = 1'b1;
    cyc("midwait_clr", ex(NONE, 5'd0, F_RUN));
    clr           = 1'b0;
    bus.mem_ready = 1'b0;

    // mem_ready low from T0 on: T0 still advances, T1 times out after 4 waits
    cyc("to_t0", ex(PC_OUT | MAR_IN | Z_IN, 5'b11111, F_RUN));
    for (int i = 0; i < 4; i++) cyc("to_wait", ex(ZLOW | PC_IN | READ | MDR_IN, 5'd0, F_RUN));
    cyc("to_pulse", ex(NONE, 5'd0, F_TO));
    cyc("to_halt", ex(NONE, 5'd0, F_HALT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencer that drives every control strobe of the Mini SRC `datapath`: register in/out enables, ALU opcode, and memory read/write with a ready handshake. It reads `IR_Data` back from the datapath and steps through the fetch phases (T0–T2) and the execute phases (T3–T7) for each instruction. It sits beside `datapath` in the CPU top level. A separate select/encode stage turns `Gra`/`Grb`/`Grc` + `Rin`/`Rout` into the R0–R15 strobes.

## Interface
- `WAIT_MAX`, default 0: cycles a memory state may wait for `mem_ready`. 0 means unbounded. Otherwise `mem_timeout` pulses and the FSM moves to HALT.
- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset, synchronous active-high.
- `IR_Data` in 32: instruction register contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `mem_ready` in 1: memory has completed the current read or write.
- `PC_out`, `PC_in`, `IR_in`, `MAR_in`, `MDR_in`, `MDR_out` out 1 each: fetch and memory path strobes.
- `Y_in`, `Z_in`, `Zlow_out`, `Zhigh_out`, `HI_in`, `HI_out`, `LO_in`, `LO_out`, `C_out` out 1 each: ALU and special-register strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: requests to the select/encode stage.
- `Read` out 1: MDR mux select (memory side) and memory read request.
- `Write` out 1: memory write request.
- `alu_instruction` out 5: ALU opcode.
- `run` out 1: 1 while executing, 0 in HALT.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout` out 1: one-cycle pulse when a memory wait expires.

## Operation
- **State register.** States: T0–T7 and HALT. Outputs are a combinational decode of (state, opcode). While `clr`=1, all strobes are forced to 0. The first edge with `clr`=1 sets the state to T0, so T0 is also the reset state and `run`=1 after reset.
- **Fetch (all instructions).**
  - T0: `PC_out`, `MAR_in`, `Z_in`, `alu_instruction`=ALU_INC.
  - T1: `Zlow_out`, `PC_in`, `Read`, `MDR_in`.
  - T2: `MDR_out`, `IR_in`.
- **R-type** (add, sub, shr, shra, shl, ror, rol, and, or).
  - T3: `Grb`, `Rout`, `Y_in`.
  - T4: `Grc`, `Rout`, `Z_in`, `alu_instruction`=opcode.
  - T5: `Zlow_out`, `Gra`, `Rin`, then go to T0.
- **Immediate** (addi, andi, ori): same as R-type except T4 drives `C_out` instead of `Grc`/`Rout`.
- **ldi**:
  - T3: `Grb`, `BAout`, `Y_in`.
  - T4: `C_out`, ADD, `Z_in`.
  - T5: `Zlow_out`, `Gra`, `Rin`.
- **ld**: T3–T4 as ldi.
  - T5: `Zlow_out`, `MAR_in`.
  - T6: `Read`, `MDR_in`.
  - T7: `MDR_out`, `Gra`, `Rin`.
- **st**: T3–T5 as ld.
  - T6: `Gra`, `Rout`, `MDR_in` (`Read`=0).
  - T7: `Write`.
- **mul, div**:
  - T3: `Gra`, `Rout`, `Y_in`.
  - T4: `Grb`, `Rout`, op, `Z_in`.
  - T5: `Zlow_out`, `LO_in`.
  - T6: `Zhigh_out`, `HI_in`.
- **neg, not**:
  - T3: `Grb`, `Rout`, op, `Z_in`.
  - T4: `Zlow_out`, `Gra`, `Rin`.
- **mfhi / mflo**: T3: `HI_out`/`LO_out`, `Gra`, `Rin`.
- **jr**: T3: `Gra`, `Rout`, `PC_in`.
- **nop**: T3 returns to T0 with no strobes.
- **halt**: T3 goes to HALT. HALT has no strobes and `run`=0, and holds until `clr`.
- **Unsupported opcodes** (branch, jal, in, out, 11100–11111): `illegal_op`=1 in T3, then go to T0.
- **Terminal states.** After the last execute state of each instruction, the FSM goes to T0.

## Timing
- **Memory states** are T1, ld T6 and st T7. Strobes are held and the state does not advance until `mem_ready`=1 is sampled at an edge. The FSM leaves the state on that edge.
- `mem_ready` in any other state is ignored.
- **Cycles per instruction** with `mem_ready` tied high:
  - 6: R-type, immediate, ldi.
  - 7: mul, div.
  - 8: ld, st.
  - 5: neg, not.
  - 4: mfhi, mflo, jr, nop.
- Each wait cycle adds 1 to the instruction's cycle count.
- **Wait counter.** It resets on entry to each memory state. With `WAIT_MAX`=N, once N cycles have passed without ready:
  - `mem_timeout` pulses for one cycle;
  - the state goes to HALT.
- **Reset.** `clr` asserted in any state, including mid-wait or HALT, forces the next state to T0 and clears the wait counter. A concurrent `mem_ready` is ignored.
- **Register writes.** `IR_Data` is sampled combinationally from T3 onward. `IR_in` in T2 is registered by the datapath, so the new opcode is valid in T3.

## Structure
- **Shared package `cpu_pkg`:**
  - the 5-bit opcode localparams (ld=00000 … halt=11011);
  - ALU_INC (5'b11111; the ALU computes B+1);
  - ALU_ADD;
  - the state enum;
  - the IR field bit positions.
- **Sub-module `cu_decode`:** combinational; maps opcode to one-hot instruction class (rtype, imm, ld, ldi, st, muldiv, unary, mfhi, mflo, jr, nop, halt, illegal).

## Test plan
- `IR_Data`=0x19890000 (add r3,r1,r2), `mem_ready`=1 → strobes exactly as specified in T0–T5, `alu_instruction`=00011 in T4, `Gra`+`Rin` in T5, back in T0 at cycle 6.
- ld r1,0x55(r2), `mem_ready` low 3 cycles in T6 → `Read`/`MDR_in` held 4 cycles, total 11 cycles, `Gra`+`Rin` in T7.
- st with `mem_ready`=1 → T6 `MDR_in` with `Read`=0, T7 `Write`=1 for exactly one cycle.
- mul r4,r5 → `LO_in` in T5, `HI_in` in T6, 7 cycles total.
- Opcode 10011 → `illegal_op` single pulse in T3, T0 next. Opcode 11011 → HALT, `run`=0 held 20 cycles, `clr` → T0, `run`=1.
- `clr` asserted in T1 mid-wait → all strobes 0 that cycle, T0 next. `WAIT_MAX`=4 with `mem_ready`=0 → `mem_timeout` pulse after 4 wait cycles, then HALT.
